// File: rtl/vec_addr_gen.sv
// vec_addr_gen: vector operand address generator for MULF/SUMF.
//
// On an accepted start, latches op/i/j/n and both base addresses, then streams
// one (addr_a, addr_b) pair per vector element over a valid/ready handshake.
//   MULF (op=0): addr_a walks row i of A (stride 1), addr_b walks column j of B
//                (stride n).
//   SUMF (op=1): addr_a and addr_b both walk row i (stride 1).
// All address arithmetic wraps silently mod 2^ADDR_W.
//
// Optional feature macro: BOUNDS_CHECK_EN
//   defined   -> i >= n, or (MULF and j >= n), with n != 0, raises sticky err
//                and skips the walk.
//   undefined -> no check; err is tied 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, op           issue pulse and operation select (0=MULF, 1=SUMF)
//   i_in, j_in, n_in    row index, column index, vector length
//   base_a, base_b      operand base addresses
//   addr_a, addr_b      generated element addresses (0 when addr_valid is low)
//   addr_valid, addr_ready  handshake for the current pair
//   last                current pair is the final element
//   busy, done, err     status: not idle, completion pulse, bounds error
module vec_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] i_in,
  input  logic [DATA_W-1:0] j_in,
  input  logic [DATA_W-1:0] n_in,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

  state_t state, state_nx;

  logic              op_q;
  logic [DATA_W-1:0] i_q, j_q, n_q;
  logic [ADDR_W-1:0] base_a_q, base_b_q;
  logic [DATA_W-1:0] k;
  logic [ADDR_W-1:0] row_off, col_ptr;
  logic [ADDR_W-1:0] row_off_nx;
  logic              is_last;
  logic              bounds_bad;

  always_comb begin
    row_off_nx = ADDR_W'(i_q) * ADDR_W'(n_q);
    is_last    = (k == (n_q - DATA_W'(1)));
`ifdef BOUNDS_CHECK_EN
    bounds_bad = (n_q != '0) && ((i_q >= n_q) || (!op_q && (j_q >= n_q)));
`else
    bounds_bad = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if ((n_q == '0) || bounds_bad) state_nx = DONE;
               else                            state_nx = ISSUE;
      ISSUE:   if (addr_ready && is_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode from state only, so an async reset clears them at once.
  always_comb begin
    addr_valid = (state == ISSUE);
    busy       = (state != IDLE);
    done       = (state == DONE);
    addr_a     = '0;
    addr_b     = '0;
    last       = 1'b0;
    if (addr_valid) begin
      addr_a = base_a_q + row_off + ADDR_W'(k);
      addr_b = base_b_q + col_ptr;
      last   = is_last;
    end
  end

  // Latched operands and walk pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      n_q      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      k        <= '0;
      row_off  <= '0;
      col_ptr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            i_q      <= i_in;
            j_q      <= j_in;
            n_q      <= n_in;
            base_a_q <= base_a;
            base_b_q <= base_b;
          end
        end
        LOAD: begin
          row_off <= row_off_nx;
          k       <= '0;
          col_ptr <= op_q ? row_off_nx : ADDR_W'(j_q);
        end
        ISSUE: begin
          if (addr_ready && !is_last) begin
            k       <= k + DATA_W'(1);
            col_ptr <= col_ptr + (op_q ? ADDR_W'(1) : ADDR_W'(n_q));
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BOUNDS_CHECK_EN
  logic err_q;

  // Sticky until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err_q <= 1'b0;
    else if (state == IDLE && start)  err_q <= 1'b0;
    else if (state == LOAD && bounds_bad) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vec_addr_gen.sv
module tb_vec_addr_gen;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, start, op, addr_ready;
  logic [DW-1:0] i_in, j_in, n_in;
  logic [AW-1:0] base_a, base_b, addr_a, addr_b;
  logic          addr_valid, last, busy, done, err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        l;
  } pair_t;

  pair_t q[$];

  always #5 clk = ~clk;

  vec_addr_gen #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .i_in(i_in), .j_in(j_in), .n_in(n_in),
    .base_a(base_a), .base_b(base_b),
    .addr_a(addr_a), .addr_b(addr_b), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .last(last),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    op     = 1'($urandom);
    i_in   = $urandom;
    j_in   = $urandom;
    n_in   = $urandom;
    base_a = $urandom;
    base_b = $urandom;
  endtask

  // mode: 0 ready always high, 1 random ready, 2 ready low 3 cycles on 2nd pair.
  // restart_at / abort_at: cycle after start at which to re-pulse start / assert rst (0 = never).
  task automatic run(input logic o, input int unsigned ii, input int unsigned jj,
                     input int unsigned nn, input logic [31:0] ba, input logic [31:0] bb,
                     input int mode, input int restart_at, input int abort_at);
    logic        exp_err;
    logic        r;
    logic        seen;
    int          stalls, accepted, stall_run, n_eff;
    pair_t       p;

    q.delete();
    exp_err = 1'b0;
`ifdef BOUNDS_CHECK_EN
    if (nn != 0 && (ii >= nn || (o == 1'b0 && jj >= nn))) exp_err = 1'b1;
`endif
    n_eff = exp_err ? 0 : int'(nn);
    for (int unsigned k = 0; k < n_eff; k++) begin
      p.a = ba + ii * nn + k;
      p.b = o ? (bb + ii * nn + k) : (bb + jj + k * nn);
      p.l = (k == nn - 1);
      q.push_back(p);
    end

    @(negedge clk);
    op = o; i_in = ii; j_in = jj; n_in = nn; base_a = ba; base_b = bb;
    start = 1'b1;

    stalls = 0; accepted = 0; stall_run = 0; seen = 1'b0;
    for (int t = 1; t <= 200 && !seen; t++) begin
      @(negedge clk);
      start = 1'b0;
      scramble();
      if (t == restart_at) start = 1'b1;
      if (t == abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", addr_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", {addr_a, addr_b}, 0);
        chk("abort_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        addr_ready = 1'b0;
        return;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: begin
          r = !(accepted == 1 && stall_run < 3);
          if (!r) stall_run++;
        end
      endcase
      addr_ready = r;
      chk("busy_walk", busy, 1);
      if (addr_valid) begin
        if (q.size() == 0) chk("valid_without_pair", addr_valid, 0);
        else begin
          chk("addr_a", addr_a, q[0].a);
          chk("addr_b", addr_b, q[0].b);
          chk("last", last, q[0].l);
          if (r) begin
            void'(q.pop_front());
            accepted++;
          end else stalls++;
        end
      end else begin
        chk("idle_outputs", {addr_a, addr_b, 31'b0, last}, 0);
      end
      if (done) begin
        seen = 1'b1;
        chk("done_time", t, n_eff + 2 + stalls);
        chk("pairs_left", q.size(), 0);
        chk("err_at_done", err, exp_err);
      end
    end
    chk("done_seen", seen, 1);

    @(negedge clk);
    addr_ready = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_valid", addr_valid, 0);
    chk("post_err", err, exp_err);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; addr_ready = 1'b0;
    op = 1'b0; i_in = '0; j_in = '0; n_in = '0; base_a = '0; base_b = '0;
    #3;
    chk("rst_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", {addr_a, addr_b, 31'b0, last}, 0);
    @(negedge clk);
    rst = 1'b0;

    // MULF row/column walk and SUMF row walk
    run(1'b0, 1, 2, 3, 32'h100, 32'h200, 0, 0, 0);
    run(1'b1, 2, 0, 4, 32'h0, 32'h40, 0, 0, 0);
    // back-pressure on the second pair
    run(1'b0, 1, 2, 3, 32'h100, 32'h200, 2, 0, 0);
    // empty vectors
    run(1'b0, 3, 3, 0, 32'h10, 32'h20, 0, 0, 0);
    run(1'b1, 3, 3, 0, 32'h10, 32'h20, 0, 0, 0);
    // start during ISSUE ignored; then reset mid-walk; then normal walk
    run(1'b0, 1, 2, 6, 32'h300, 32'h400, 0, 3, 0);
    run(1'b0, 1, 2, 6, 32'h300, 32'h400, 0, 3, 5);
    run(1'b1, 2, 0, 4, 32'h0, 32'h40, 0, 0, 0);
    // out-of-range column index
    run(1'b0, 0, 5, 4, 32'h500, 32'h600, 0, 0, 0);
    // address wrap-around
    run(1'b1, 3, 0, 5, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 1, 0, 0);
    run(1'b0, 2, 1, 4, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1, 0, 0);

    for (int x = 0; x < 24; x++) begin
      run(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom, $urandom, 1, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
